// File: rtl/mod_classifier_pkg.sv
// Shared class and decision-FSM encodings for the modulation classifier.
// The display/report stage imports these same definitions.
package mod_classifier_pkg;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_CW   = 3'd1,
        CLS_AM   = 3'd2,
        CLS_ASK  = 3'd3,
        CLS_FM   = 3'd4
    } mod_class_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_CONFIRM  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/mod_classifier_if.sv
// Measurement-in / classification-out bundle of the modulation classifier.
interface mod_classifier_if #(
    parameter int N = 8
);
    logic         meas_valid;
    logic [N-1:0] vpp;
    logic [N-1:0] papr;
    logic         is_sine_wave;
    logic [2:0]   mod_type;
    logic         mod_valid;
    logic         locked;

    modport master (
        output meas_valid, vpp, papr, is_sine_wave,
        input  mod_type, mod_valid, locked
    );

    modport slave (
        input  meas_valid, vpp, papr, is_sine_wave,
        output mod_type, mod_valid, locked
    );
endinterface

// File: rtl/mod_classifier_win_stats.sv
// Per-window frame statistics; the closing frame is folded in and copied to a snapshot.
module win_stats #(
    parameter int N          = 8,
    parameter int WIN_FRAMES = 8,
    parameter int LOG2_WIN   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  meas_valid,
    input  logic [N-1:0]          vpp,
    input  logic [N-1:0]          papr,
    input  logic                  is_sine_wave,
    output logic                  snap_valid,
    output logic [N-1:0]          snap_vpp_max,
    output logic [N-1:0]          snap_vpp_min,
    output logic [LOG2_WIN:0]     snap_sine_cnt,
    output logic [N+LOG2_WIN-1:0] snap_papr_sum
);
    localparam int SUM_W = N + LOG2_WIN;
    localparam int CNT_W = LOG2_WIN + 1;

    logic [CNT_W-1:0] frame_cnt;
    logic [N-1:0]     acc_max, acc_min, nxt_max, nxt_min;
    logic [CNT_W-1:0] acc_sine, nxt_sine;
    logic [SUM_W-1:0] acc_sum, nxt_sum;
    logic             closing;

    always_comb begin
        nxt_max  = (vpp > acc_max) ? vpp : acc_max;
        nxt_min  = (vpp < acc_min) ? vpp : acc_min;
        nxt_sine = acc_sine + CNT_W'(is_sine_wave);
        nxt_sum  = acc_sum + SUM_W'(papr);
        closing  = meas_valid && (frame_cnt == CNT_W'(WIN_FRAMES - 1));
    end

    // Accumulators return to "empty" on the closing edge so the next frame starts a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt     <= '0;
            acc_max       <= '0;
            acc_min       <= '1;
            acc_sine      <= '0;
            acc_sum       <= '0;
            snap_valid    <= 1'b0;
            snap_vpp_max  <= '0;
            snap_vpp_min  <= '0;
            snap_sine_cnt <= '0;
            snap_papr_sum <= '0;
        end else begin
            snap_valid <= closing;
            if (closing) begin
                snap_vpp_max  <= nxt_max;
                snap_vpp_min  <= nxt_min;
                snap_sine_cnt <= nxt_sine;
                snap_papr_sum <= nxt_sum;
                acc_max       <= '0;
                acc_min       <= '1;
                acc_sine      <= '0;
                acc_sum       <= '0;
                frame_cnt     <= '0;
            end else if (meas_valid) begin
                acc_max   <= nxt_max;
                acc_min   <= nxt_min;
                acc_sine  <= nxt_sine;
                acc_sum   <= nxt_sum;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mod_classifier.sv
// Modulation classifier: window decision FSM with N-window confirmation before publishing.
//   state       | meaning
//   ST_IDLE     | waiting for a fresh (or pending) window snapshot
//   ST_CLASSIFY | register the candidate class from the snapshot
//   ST_CONFIRM  | compare with previous candidate, update lock, maybe publish
module mod_classifier
    import mod_classifier_pkg::*;
#(
    parameter int N          = 8,
    parameter int WIN_FRAMES = 8,
    parameter int LOG2_WIN   = 3,
    parameter int VPP_MIN    = 16,
    parameter int AM_SPAN    = 24,
    parameter int PAPR_LO    = 6,
    parameter int PAPR_HI    = 10,
    parameter int CONFIRM    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mod_classifier_if.slave bus
);
    localparam int SUM_W   = N + LOG2_WIN;
    localparam int CNT_W   = LOG2_WIN + 1;
    localparam int MATCH_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

    logic             snap_valid;
    logic [N-1:0]     snap_vpp_max, snap_vpp_min, span;
    logic [CNT_W-1:0] snap_sine_cnt;
    logic [SUM_W-1:0] snap_papr_sum, papr_avg;

    fsm_state_e       state_q, state_d;
    logic             pending_q;
    mod_class_e       cls_d, cand_q, prev_q, mod_type_q;
    logic [MATCH_W-1:0] match_q, match_d;
    logic             locked_q, locked_d, mod_valid_q, publish;

    win_stats #(
        .N          (N),
        .WIN_FRAMES (WIN_FRAMES),
        .LOG2_WIN   (LOG2_WIN)
    ) u_win_stats (
        .clk           (clk),
        .rst_n         (rst_n),
        .meas_valid    (bus.meas_valid),
        .vpp           (bus.vpp),
        .papr          (bus.papr),
        .is_sine_wave  (bus.is_sine_wave),
        .snap_valid    (snap_valid),
        .snap_vpp_max  (snap_vpp_max),
        .snap_vpp_min  (snap_vpp_min),
        .snap_sine_cnt (snap_sine_cnt),
        .snap_papr_sum (snap_papr_sum)
    );

    // First-match priority: absent carrier, keyed-off frames, envelope swing, steady sine, else FM.
    always_comb begin
        span     = snap_vpp_max - snap_vpp_min;
        papr_avg = snap_papr_sum >> LOG2_WIN;
        cls_d    = CLS_FM;
        if (snap_vpp_max < N'(VPP_MIN))
            cls_d = CLS_NONE;
        else if (snap_vpp_min < N'(VPP_MIN))
            cls_d = CLS_ASK;
        else if (span >= N'(AM_SPAN))
            cls_d = CLS_AM;
        else if ((snap_sine_cnt == CNT_W'(WIN_FRAMES)) &&
                 (papr_avg >= SUM_W'(PAPR_LO)) && (papr_avg <= SUM_W'(PAPR_HI)))
            cls_d = CLS_CW;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (snap_valid || pending_q) state_d = ST_CLASSIFY;
            ST_CLASSIFY: state_d = ST_CONFIRM;
            ST_CONFIRM:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        match_d  = 1'b1;
        locked_d = 1'b0;
        if (cand_q == prev_q) begin
            match_d  = (match_q >= MATCH_W'(CONFIRM)) ? match_q : match_q + 1'b1;
            locked_d = locked_q;
        end
        publish = (match_d == MATCH_W'(CONFIRM)) && ((cand_q != mod_type_q) || !locked_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            cand_q      <= CLS_NONE;
            prev_q      <= CLS_NONE;
            match_q     <= '0;
            mod_type_q  <= CLS_NONE;
            locked_q    <= 1'b0;
            mod_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mod_valid_q <= 1'b0;
            // A snapshot landing mid-decision is remembered and picked up on the next IDLE cycle.
            if (state_q == ST_IDLE)
                pending_q <= 1'b0;
            else if (snap_valid)
                pending_q <= 1'b1;
            if (state_q == ST_CLASSIFY)
                cand_q <= cls_d;
            if (state_q == ST_CONFIRM) begin
                match_q     <= match_d;
                prev_q      <= cand_q;
                locked_q    <= publish | locked_d;
                mod_valid_q <= publish;
                if (publish)
                    mod_type_q <= cand_q;
            end
        end
    end

    assign bus.mod_type  = mod_type_q;
    assign bus.mod_valid = mod_valid_q;
    assign bus.locked    = locked_q;
endmodule
